// File: rtl/matvec_stream_engine.sv
// Streaming y = A*x engine: LANES rows per group, one NI-element chunk per lane per beat.
// Optional build macro MATVEC_SATURATE_EN: saturating accumulation plus a sat_flag output.
module matvec_stream_engine #(
  parameter int EW        = 16,
  parameter int NI        = 8,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 40,
  parameter int IDX_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [IDX_WIDTH-1:0]      n_rows,
  input  logic [IDX_WIDTH-1:0]      n_chunks,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [LANES*NI*EW-1:0]    a_data,
  input  logic [NI*EW-1:0]          x_data,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic [ACC_WIDTH-1:0]      y_data,
  output logic [IDX_WIDTH-1:0]      y_index,
`ifdef MATVEC_SATURATE_EN
  output logic                      sat_flag,
`endif
  output logic                      busy,
  output logic                      done
);

  localparam int FULL_W = 2 * EW + $clog2(NI);
  localparam int BW     = ((FULL_W > ACC_WIDTH) ? FULL_W : ACC_WIDTH) + 1;
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2, FINISH = 2'd3} state_t;

  state_t                       state_r;
  logic [IDX_WIDTH-1:0]         rows_r, chunks_r, chunk_r, row_base_r;
  logic [LW-1:0]                lane_r;
  logic signed [ACC_WIDTH-1:0]  acc_r     [LANES];
  logic signed [ACC_WIDTH-1:0]  out_buf_r [LANES];
  logic signed [ACC_WIDTH-1:0]  acc_nxt_s [LANES];
  logic signed [BW-1:0]         dot_s;
  logic signed [ACC_WIDTH-1:0]  ps_s;
  logic                         first_s, beat_s, last_beat_s, last_lane_s, more_groups_s;
  logic [IDX_WIDTH:0]           next_row_s;

  // Exact dot product of one lane chunk with the vector chunk.
  function automatic logic signed [BW-1:0] lane_dot(input logic [NI*EW-1:0] a,
                                                    input logic [NI*EW-1:0] x);
    logic signed [2*EW-1:0] ae, xe, p;
    logic signed [BW-1:0]   s;
    s = '0;
    for (int k = 0; k < NI; k++) begin
      ae = {{EW{a[k*EW+EW-1]}}, a[k*EW +: EW]};
      xe = {{EW{x[k*EW+EW-1]}}, x[k*EW +: EW]};
      p  = ae * xe;
      s  = s + {{(BW-2*EW){p[2*EW-1]}}, p};
    end
    return s;
  endfunction

`ifdef MATVEC_SATURATE_EN
  function automatic logic in_acc_range(input logic signed [BW-1:0] v);
    return (&v[BW-1:ACC_WIDTH-1]) || !(|v[BW-1:ACC_WIDTH-1]);
  endfunction

  function automatic logic signed [BW-1:0] sext_acc(input logic signed [ACC_WIDTH-1:0] v);
    return {{(BW-ACC_WIDTH){v[ACC_WIDTH-1]}}, v};
  endfunction
`endif

  // Narrow a wide value to the accumulator width (clamp or wrap).
  function automatic logic signed [ACC_WIDTH-1:0] fit_acc(input logic signed [BW-1:0] v);
`ifdef MATVEC_SATURATE_EN
    if (in_acc_range(v)) return v[ACC_WIDTH-1:0];
    else if (v[BW-1]) return {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else return {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
    return v[ACC_WIDTH-1:0];
`endif
  endfunction

  assign first_s       = (chunk_r == {IDX_WIDTH{1'b0}});
  assign beat_s        = (state_r == LOAD) && a_valid && a_ready;
  assign last_beat_s   = (chunk_r == chunks_r - IDX_WIDTH'(1));
  assign next_row_s    = {1'b0, row_base_r} + {{(IDX_WIDTH+1-LW){1'b0}}, lane_r} + (IDX_WIDTH+1)'(1);
  assign last_lane_s   = (lane_r == LW'(LANES-1)) || (next_row_s >= {1'b0, rows_r});
  assign more_groups_s = ({1'b0, row_base_r} + (IDX_WIDTH+1)'(LANES)) < {1'b0, rows_r};

`ifdef MATVEC_SATURATE_EN
  logic signed [BW-1:0] sum_s;
  logic [LANES-1:0]     sat_acc_r, sat_buf_r, sat_nxt_s;

  // Per-lane saturating accumulate and sticky overflow tracking.
  always_comb begin
    dot_s     = '0;
    ps_s      = '0;
    sum_s     = '0;
    sat_nxt_s = '0;
    for (int j = 0; j < LANES; j++) begin
      dot_s        = lane_dot(a_data[j*NI*EW +: NI*EW], x_data);
      ps_s         = fit_acc(dot_s);
      sum_s        = first_s ? sext_acc(ps_s) : sext_acc(acc_r[j]) + sext_acc(ps_s);
      acc_nxt_s[j] = fit_acc(sum_s);
      sat_nxt_s[j] = !in_acc_range(dot_s) || !in_acc_range(sum_s) || (!first_s && sat_acc_r[j]);
    end
  end
`else
  // Per-lane wrap-around accumulate.
  always_comb begin
    dot_s = '0;
    ps_s  = '0;
    for (int j = 0; j < LANES; j++) begin
      dot_s        = lane_dot(a_data[j*NI*EW +: NI*EW], x_data);
      ps_s         = fit_acc(dot_s);
      acc_nxt_s[j] = first_s ? ps_s : acc_r[j] + ps_s;
    end
  end
`endif

  // Job control FSM with registered stream and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      rows_r     <= '0;
      chunks_r   <= '0;
      chunk_r    <= '0;
      row_base_r <= '0;
      lane_r     <= '0;
      a_ready    <= 1'b0;
      y_valid    <= 1'b0;
      y_data     <= '0;
      y_index    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int j = 0; j < LANES; j++) begin
        acc_r[j]     <= '0;
        out_buf_r[j] <= '0;
      end
`ifdef MATVEC_SATURATE_EN
      sat_acc_r <= '0;
      sat_buf_r <= '0;
      sat_flag  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if ((n_rows == {IDX_WIDTH{1'b0}}) || (n_chunks == {IDX_WIDTH{1'b0}})) begin
              state_r <= FINISH;
            end else begin
              rows_r     <= n_rows;
              chunks_r   <= n_chunks;
              chunk_r    <= '0;
              row_base_r <= '0;
              a_ready    <= 1'b1;
              state_r    <= LOAD;
              for (int j = 0; j < LANES; j++) acc_r[j] <= '0;
            end
          end
        end
        LOAD: begin
          if (beat_s) begin
            acc_r <= acc_nxt_s;
`ifdef MATVEC_SATURATE_EN
            sat_acc_r <= sat_nxt_s;
`endif
            if (last_beat_s) begin
              out_buf_r <= acc_nxt_s;
              a_ready   <= 1'b0;
              y_valid   <= 1'b1;
              y_data    <= acc_nxt_s[0];
              y_index   <= row_base_r;
              lane_r    <= '0;
              chunk_r   <= '0;
              state_r   <= DRAIN;
`ifdef MATVEC_SATURATE_EN
              sat_buf_r <= sat_nxt_s;
              sat_flag  <= sat_nxt_s[0];
`endif
            end else begin
              chunk_r <= chunk_r + IDX_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (y_ready) begin
            if (last_lane_s) begin
              y_valid <= 1'b0;
`ifdef MATVEC_SATURATE_EN
              sat_flag <= 1'b0;
`endif
              if (more_groups_s) begin
                row_base_r <= row_base_r + IDX_WIDTH'(LANES);
                a_ready    <= 1'b1;
                state_r    <= LOAD;
              end else begin
                state_r <= FINISH;
              end
            end else begin
              lane_r  <= lane_r + LW'(1);
              y_data  <= out_buf_r[lane_r + LW'(1)];
              y_index <= y_index + IDX_WIDTH'(1);
`ifdef MATVEC_SATURATE_EN
              sat_flag <= sat_buf_r[lane_r + LW'(1)];
`endif
            end
          end
        end
        FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_stream_engine.sv
// Scoreboard bench for matvec_stream_engine: expected rows queued at job start, checked on y handshakes.
module tb_matvec_stream_engine;
  localparam int EW = 16, NI = 8, LANES = 4, ACC_WIDTH = 40, IDX_WIDTH = 16;

  logic                   clk = 1'b0;
  logic                   reset, start, a_valid, y_ready;
  logic [IDX_WIDTH-1:0]   n_rows, n_chunks, y_index;
  logic [LANES*NI*EW-1:0] a_data;
  logic [NI*EW-1:0]       x_data;
  logic                   a_ready, y_valid, busy, done;
  logic [ACC_WIDTH-1:0]   y_data;
`ifdef MATVEC_SATURATE_EN
  logic                   sat_flag;
`endif

  typedef struct {
    logic [IDX_WIDTH-1:0] idx;
    logic [ACC_WIDTH-1:0] data;
    logic                 sat;
  } exp_t;

  exp_t       sb[$];
  int         total = 0, bad = 0;
  int         done_cnt = 0, yh_cnt = 0;
  logic [1:0] yr_mode = 2'd0;

  matvec_stream_engine #(.EW(EW), .NI(NI), .LANES(LANES), .ACC_WIDTH(ACC_WIDTH), .IDX_WIDTH(IDX_WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .n_rows(n_rows), .n_chunks(n_chunks),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .x_data(x_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_index(y_index),
`ifdef MATVEC_SATURATE_EN
    .sat_flag(sat_flag),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // y_ready policy: 0 always ready, 1 random, 2 held low
  always @(posedge clk) begin
    #1;
    case (yr_mode)
      2'd0:    y_ready = 1'b1;
      2'd1:    y_ready = ($urandom_range(0, 2) != 0);
      default: y_ready = 1'b0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] hash16(input int unsigned s);
    logic [31:0] h;
    h = s * 32'h9E3779B1;
    h = h ^ (h >> 15);
    return h[31:16];
  endfunction

  function automatic logic [15:0] a_el(input int pat, input int r, input int c, input int k);
    case (pat)
      0:       return (r == k) ? 16'd1 : 16'd0;
      1:       return 16'd1;
      2:       return 16'h7FFF;
      default: return hash16(r * 977 + c * 31 + k);
    endcase
  endfunction

  function automatic logic [15:0] x_el(input int pat, input int c, input int k);
    case (pat)
      0:       return 16'(k + 1);
      1:       return 16'd1;
      2:       return 16'h7FFF;
      default: return hash16(50000 + c * 13 + k);
    endcase
  endfunction

  function automatic logic [LANES*NI*EW-1:0] make_a(input int pat, input int g, input int c);
    logic [LANES*NI*EW-1:0] v;
    for (int j = 0; j < LANES; j++)
      for (int k = 0; k < NI; k++)
        v[(j*NI+k)*EW +: EW] = a_el(pat, g * LANES + j, c, k);
    return v;
  endfunction

  function automatic logic [NI*EW-1:0] make_x(input int pat, input int c);
    logic [NI*EW-1:0] v;
    for (int k = 0; k < NI; k++) v[k*EW +: EW] = x_el(pat, c, k);
    return v;
  endfunction

  // Reference row result from exact 64-bit arithmetic.
  function automatic exp_t model_row(input int pat, input int r, input int nc);
    exp_t   e;
    longint acc, ps;
    longint hi, lo;
    logic [63:0] accv;
    hi = (longint'(1) <<< (ACC_WIDTH - 1)) - 1;
    lo = -(longint'(1) <<< (ACC_WIDTH - 1));
    acc = 0;
    e.sat = 1'b0;
    for (int c = 0; c < nc; c++) begin
      ps = 0;
      for (int k = 0; k < NI; k++)
        ps += longint'($signed(a_el(pat, r, c, k))) * longint'($signed(x_el(pat, c, k)));
`ifdef MATVEC_SATURATE_EN
      if (ps > hi) begin ps = hi; e.sat = 1'b1; end
      if (ps < lo) begin ps = lo; e.sat = 1'b1; end
      acc = acc + ps;
      if (acc > hi) begin acc = hi; e.sat = 1'b1; end
      if (acc < lo) begin acc = lo; e.sat = 1'b1; end
`else
      acc = acc + ps;
`endif
    end
    accv   = acc;
    e.idx  = IDX_WIDTH'(r);
    e.data = accv[ACC_WIDTH-1:0];
    return e;
  endfunction

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check_eq("busy_at_done", 64'(busy), 64'd0);
      end
      if (y_valid && y_ready) begin
        yh_cnt++;
        if (sb.size() == 0) begin
          check_eq("unexpected_y", 64'(y_index), 64'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check_eq("y_index", 64'(y_index), 64'(e.idx));
          check_eq("y_data", 64'(y_data), 64'(e.data));
`ifdef MATVEC_SATURATE_EN
          check_eq("sat_flag", 64'(sat_flag), 64'(e.sat));
`endif
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_a_ready"}, 64'(a_ready), 64'd0);
    check_eq({tag, "_y_valid"}, 64'(y_valid), 64'd0);
    check_eq({tag, "_y_data"},  64'(y_data),  64'd0);
    check_eq({tag, "_y_index"}, 64'(y_index), 64'd0);
    check_eq({tag, "_busy"},    64'(busy),    64'd0);
    check_eq({tag, "_done"},    64'(done),    64'd0);
  endtask

  task automatic run_job(input int nr, input int nc, input int pat, input bit gaps,
                         input bit poke, input bit bp);
    int groups, d0, t;
    bit ok;
    logic [ACC_WIDTH-1:0] hold_d;
    logic [IDX_WIDTH-1:0] hold_i;
    groups = (nr + LANES - 1) / LANES;
    for (int r = 0; r < nr; r++) sb.push_back(model_row(pat, r, nc));
    d0 = done_cnt;
    n_rows = IDX_WIDTH'(nr);
    n_chunks = IDX_WIDTH'(nc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", 64'(busy), 64'd1);
    for (int g = 0; g < groups; g++) begin
      for (int c = 0; c < nc; c++) begin
        t = 0;
        ok = 1'b0;
        while (!ok) begin
          a_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
          a_data  = make_a(pat, g, c);
          x_data  = make_x(pat, c);
          start   = poke && (g == 0) && (c == 1);
          n_rows  = start ? '0 : IDX_WIDTH'(nr);
          @(negedge clk);
          ok = a_valid && a_ready;
          @(posedge clk); #1;
          start = 1'b0;
          if (++t > 2000) begin
            check_eq("beat_timeout", 64'd0, 64'd1);
            a_valid = 1'b0;
            return;
          end
        end
      end
      a_valid = 1'b0;
      if (bp && g == 0) begin
        t = 0;
        do begin @(negedge clk); t++; end while (!y_valid && t < 100);
        hold_d = y_data;
        hold_i = y_index;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check_eq("bp_y_data", 64'(y_data), 64'(hold_d));
          check_eq("bp_y_index", 64'(y_index), 64'(hold_i));
          check_eq("bp_a_ready", 64'(a_ready), 64'd0);
          check_eq("bp_y_valid", 64'(y_valid), 64'd1);
        end
        yr_mode = 2'd0;
      end
    end
    t = 0;
    while (done_cnt == d0 && t < 500) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_once", 64'(done_cnt - d0), 64'd1);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int d0, y0;
    fork monitor_loop(); join_none
    reset = 1'b1; start = 1'b0; a_valid = 1'b0; n_rows = '0; n_chunks = '0;
    a_data = '0; x_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    @(posedge clk); #1;
    yr_mode = 2'd0;
    run_job(4, 1, 0, 1'b0, 1'b0, 1'b0);
    run_job(6, 2, 1, 1'b0, 1'b1, 1'b0);
    yr_mode = 2'd2;
    run_job(4, 3, 3, 1'b1, 1'b0, 1'b1);
    yr_mode = 2'd1;
    run_job(5, 3, 3, 1'b1, 1'b0, 1'b0);

    // zero-size job: done exactly two cycles after start, no results
    d0 = done_cnt;
    y0 = yh_cnt;
    n_rows = '0; n_chunks = 16'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("zero_done_c1", 64'(done), 64'd0);
    @(negedge clk);
    check_eq("zero_done_c2", 64'(done), 64'd1);
    @(negedge clk);
    check_eq("zero_done_c3", 64'(done), 64'd0);
    check_eq("zero_no_y", 64'(yh_cnt - y0), 64'd0);
    check_eq("zero_done_cnt", 64'(done_cnt - d0), 64'd1);
    @(posedge clk); #1;

    yr_mode = 2'd0;
    run_job(4, 4096, 2, 1'b0, 1'b0, 1'b0);

    // abort a job mid-load after three beats
    n_rows = 16'd4; n_chunks = 16'd8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      a_valid = 1'b1;
      a_data  = make_a(3, 0, b);
      x_data  = make_x(3, b);
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    d0 = done_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    repeat (4) @(posedge clk);
    #1;
    check_eq("abort_no_done", 64'(done_cnt - d0), 64'd0);

    yr_mode = 2'd1;
    run_job(7, 2, 3, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
